// File: rtl/mips_trace_buffer.sv
// mips_trace_buffer: circular trace capture of register and data-memory writes
// with a PC-match trigger, a post-trigger capture window and valid/ready readout.
// Optional macro MIPS_TRACE_DISPLAY_EN adds simulation-only $display logging of
// every capture; the buffer behaves identically with or without it.
//
// state | meaning
// IDLE  | no capture, waiting for arm
// ARMED | capturing into the ring, watching for the trigger PC
// POST  | capturing the post-trigger window
// DONE  | capture frozen, buffer drained oldest-first via rd_valid/rd_ready
module mips_trace_buffer #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 32,
  parameter int TS_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [31:0]                pc,
  input  logic                       reg_we,
  input  logic [4:0]                 reg_waddr,
  input  logic [DATA_W-1:0]          reg_wdata,
  input  logic                       mem_we,
  input  logic [31:0]                mem_addr,
  input  logic [DATA_W-1:0]          mem_wdata,
  input  logic                       arm,
  input  logic [31:0]                trig_pc,
  input  logic [$clog2(DEPTH):0]     post_count,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [TS_W-1:0]            rd_ts,
  output logic [31:0]                rd_pc,
  output logic [1:0]                 rd_flags,
  output logic [4:0]                 rd_reg_addr,
  output logic [DATA_W-1:0]          rd_reg_data,
  output logic [31:0]                rd_mem_addr,
  output logic [DATA_W-1:0]          rd_mem_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       triggered,
  output logic                       overflow,
  output logic [1:0]                 state
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3} state_t;

  state_t          cur, nxt;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt, post_lat, post_cnt;
  logic [31:0]     trig_lat;
  logic [TS_W-1:0] ts;
  logic            reg_ev, ev, cap, trig_hit, rd_fire, full;

  logic [TS_W-1:0]   m_ts    [DEPTH];
  logic [31:0]       m_pc    [DEPTH];
  logic [1:0]        m_flags [DEPTH];
  logic [4:0]        m_raddr [DEPTH];
  logic [DATA_W-1:0] m_rdata [DEPTH];
  logic [31:0]       m_maddr [DEPTH];
  logic [DATA_W-1:0] m_mdata [DEPTH];

  assign reg_ev = reg_we && (reg_waddr != 5'd0);
  assign ev     = en && (reg_ev || mem_we);
  assign full   = (cnt == CW'(DEPTH));
  assign count  = cnt;
  assign state  = cur;

  // State register
  always_ff @(posedge clk) begin
    if (rst) cur <= IDLE;
    else     cur <= nxt;
  end

  // Next-state logic; arm overrides every state
  always_comb begin
    nxt = cur;
    if (arm) nxt = ARMED;
    else begin
      case (cur)
        ARMED:   if (trig_hit) nxt = (post_lat != '0) ? POST : DONE;
        POST:    if (cap && (post_cnt + CW'(1) == post_lat)) nxt = DONE;
        default: nxt = cur;
      endcase
    end
  end

  // Output/strobe decode; an arm cycle suppresses capture, trigger and readout
  always_comb begin
    cap      = !arm && ev && (cur == ARMED || cur == POST);
    trig_hit = !arm && (cur == ARMED) && en && (pc == trig_lat);
    rd_valid = (cur == DONE) && (cnt != '0);
    rd_fire  = !arm && rd_valid && rd_ready;
  end

  // Pointers, occupancy, timestamp, sticky flags and latched arm settings
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      ts        <= '0;
      triggered <= 1'b0;
      overflow  <= 1'b0;
      post_cnt  <= '0;
      post_lat  <= '0;
      trig_lat  <= '0;
    end else begin
      if (en) ts <= ts + 1'b1;
      if (arm) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        cnt       <= '0;
        triggered <= 1'b0;
        overflow  <= 1'b0;
        post_cnt  <= '0;
        trig_lat  <= trig_pc;
        post_lat  <= (post_count > CW'(DEPTH)) ? CW'(DEPTH) : post_count;
      end else begin
        if (cap) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (full) begin
            rd_ptr   <= rd_ptr + 1'b1;
            overflow <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
          if (cur == POST) post_cnt <= post_cnt + 1'b1;
        end
        if (trig_hit) triggered <= 1'b1;
        if (rd_fire) begin
          rd_ptr <= rd_ptr + 1'b1;
          cnt    <= cnt - 1'b1;
        end
      end
    end
  end

  // Entry RAM write; contents survive reset
  always_ff @(posedge clk) begin
    if (!rst && cap) begin
      m_ts[wr_ptr]    <= ts;
      m_pc[wr_ptr]    <= pc;
      m_flags[wr_ptr] <= {mem_we, reg_ev};
      m_raddr[wr_ptr] <= reg_waddr;
      m_rdata[wr_ptr] <= reg_wdata;
      m_maddr[wr_ptr] <= mem_addr;
      m_mdata[wr_ptr] <= mem_wdata;
    end
  end

  assign rd_ts       = m_ts[rd_ptr];
  assign rd_pc       = m_pc[rd_ptr];
  assign rd_flags    = m_flags[rd_ptr];
  assign rd_reg_addr = m_raddr[rd_ptr];
  assign rd_reg_data = m_rdata[rd_ptr];
  assign rd_mem_addr = m_maddr[rd_ptr];
  assign rd_mem_data = m_mdata[rd_ptr];

`ifdef MIPS_TRACE_DISPLAY_EN
  // Simulation log of each captured side effect and of the trigger
  always_ff @(posedge clk) begin
    if (!rst && cap && reg_ev)
      $display("ts:%0d pc:%0d value 0x%0h written to register: %0d", ts, pc, reg_wdata, reg_waddr);
    if (!rst && cap && mem_we)
      $display("ts:%0d pc:%0d value 0x%0h written to memory address: 0x%0h", ts, pc, mem_wdata, mem_addr);
    if (!rst && trig_hit)
      $display("trigger at pc:%0d", pc);
  end
`else
  // Logging disabled: pure synthesizable buffer
`endif

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Testbench for mips_trace_buffer: reference model with a scoreboard queue of
// expected entries, a table-driven readout handshake and directed corner cases.
module tb_mips_trace_buffer;
  localparam int DEPTH = 64, DATA_W = 32, TS_W = 16, CW = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, reg_we = 1'b0, mem_we = 1'b0, arm = 1'b0, rd_ready = 1'b0;
  logic [31:0] pc = '0, mem_addr = '0, trig_pc = '0;
  logic [4:0] reg_waddr = '0;
  logic [DATA_W-1:0] reg_wdata = '0, mem_wdata = '0;
  logic [CW-1:0] post_count = '0;
  logic rd_valid, triggered, overflow;
  logic [TS_W-1:0] rd_ts;
  logic [31:0] rd_pc, rd_mem_addr;
  logic [1:0] rd_flags, state;
  logic [4:0] rd_reg_addr;
  logic [DATA_W-1:0] rd_reg_data, rd_mem_data;
  logic [CW-1:0] count;

  mips_trace_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TS_W(TS_W)) dut (
    .clk(clk), .rst(rst), .en(en), .pc(pc), .reg_we(reg_we), .reg_waddr(reg_waddr),
    .reg_wdata(reg_wdata), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .arm(arm), .trig_pc(trig_pc), .post_count(post_count), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_ts(rd_ts), .rd_pc(rd_pc), .rd_flags(rd_flags),
    .rd_reg_addr(rd_reg_addr), .rd_reg_data(rd_reg_data), .rd_mem_addr(rd_mem_addr),
    .rd_mem_data(rd_mem_data), .count(count), .triggered(triggered), .overflow(overflow),
    .state(state));

  always #5 clk = ~clk;

  typedef struct {
    logic [TS_W-1:0]   ts;
    logic [31:0]       pc;
    logic [1:0]        flags;
    logic [4:0]        ra;
    logic [DATA_W-1:0] rd;
    logic [31:0]       ma;
    logic [DATA_W-1:0] md;
  } entry_t;

  typedef struct {
    logic rdy;
    logic exp_v;
    int   exp_cnt;
  } hs_t;

  entry_t sb[$];
  hs_t    tbl[5];
  int n_chk = 0, n_fail = 0;
  int m_st = 0, m_post = 0, m_pcnt = 0;
  logic [31:0] m_tpc = '0, last_pc = '0;
  logic [TS_W-1:0] ts_model = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: check readout against the model, advance the model, then the edge
  task automatic cyc();
    entry_t e;
    logic ev, rev;
    if (!rst) begin
      chk("rd_valid", rd_valid, 64'(m_st == 3 && sb.size() != 0));
      if (m_st == 3 && sb.size() != 0 && rd_ready && !arm) begin
        e = sb.pop_front();
        last_pc = rd_pc;
        chk("rd_ts", rd_ts, e.ts);
        chk("rd_pc", rd_pc, e.pc);
        chk("rd_flags", rd_flags, e.flags);
        if (e.flags[0]) begin
          chk("rd_reg_addr", rd_reg_addr, e.ra);
          chk("rd_reg_data", rd_reg_data, e.rd);
        end
        if (e.flags[1]) begin
          chk("rd_mem_addr", rd_mem_addr, e.ma);
          chk("rd_mem_data", rd_mem_data, e.md);
        end
      end
    end
    if (rst) begin
      m_st = 0; ts_model = '0; sb.delete();
    end else begin
      if (arm) begin
        sb.delete(); m_st = 1; m_tpc = trig_pc; m_pcnt = 0;
        m_post = (int'(post_count) > DEPTH) ? DEPTH : int'(post_count);
      end else begin
        rev = reg_we && reg_waddr != 0;
        ev  = en && (rev || mem_we);
        if ((m_st == 1 || m_st == 2) && ev) begin
          e = '{ts_model, pc, {mem_we, rev}, reg_waddr, reg_wdata, mem_addr, mem_wdata};
          sb.push_back(e);
          if (sb.size() > DEPTH) void'(sb.pop_front());
        end
        if (m_st == 1 && en && pc == m_tpc) m_st = (m_post > 0) ? 2 : 3;
        else if (m_st == 2 && ev) begin
          m_pcnt++;
          if (m_pcnt == m_post) m_st = 3;
        end
      end
      if (en) ts_model = ts_model + 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_ev(input logic [31:0] p, input logic rwe, input logic [4:0] ra,
                        input logic [31:0] rdat, input logic mwe, input logic [31:0] ma,
                        input logic [31:0] md);
    en = 1'b1; pc = p; reg_we = rwe; reg_waddr = ra; reg_wdata = rdat;
    mem_we = mwe; mem_addr = ma; mem_wdata = md;
  endtask

  task automatic idle();
    en = 1'b0; reg_we = 1'b0; mem_we = 1'b0;
  endtask

  task automatic do_arm(input logic [31:0] tp, input int pcount);
    arm = 1'b1; trig_pc = tp; post_count = CW'(pcount);
    cyc();
    arm = 1'b0;
  endtask

  task automatic drain();
    rd_ready = 1'b1; idle();
    for (int k = 0; k < 200 && rd_valid; k++) cyc();
    chk("drain_done", rd_valid, 0);
    rd_ready = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 2};
    tbl[1] = '{1'b0, 1'b1, 2};
    tbl[2] = '{1'b1, 1'b1, 1};
    tbl[3] = '{1'b1, 1'b1, 0};
    tbl[4] = '{1'b1, 1'b0, 0};

    // Reset and idle: writes in IDLE are ignored
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("reset_count", count, 0);
    chk("reset_state", state, 0);
    chk("reset_trig", triggered, 0);
    chk("reset_ovf", overflow, 0);
    for (int i = 0; i < 10; i++) begin
      set_ev(32'h10 + 32'(4 * i), 1'b1, 5'd3, 32'(i), 1'b0, '0, '0);
      cyc();
    end
    chk("idle_count", count, 0);
    chk("idle_state", state, 0);
    chk("idle_valid", rd_valid, 0);

    // $zero filter and coincident reg+mem write in one entry
    idle(); do_arm(32'h200, 0);
    set_ev(32'h1fc, 1'b1, 5'd0, 32'h5555, 1'b0, '0, '0); cyc();
    set_ev(32'h200, 1'b1, 5'd5, 32'h1234, 1'b1, 32'h40, 32'hBEEF); cyc();
    idle(); cyc();
    chk("coin_count", count, 1);
    chk("coin_state", state, 3);
    chk("coin_flags", rd_flags, 2'b11);
    chk("coin_raddr", rd_reg_addr, 5);
    chk("coin_rdata", rd_reg_data, 32'h1234);
    chk("coin_maddr", rd_mem_addr, 32'h40);
    chk("coin_mdata", rd_mem_data, 32'hBEEF);
    drain();

    // Wrap and overflow: 100 captures into a 64-entry ring
    do_arm(32'h5000, 0);
    for (int i = 1; i <= 100; i++) begin
      set_ev(32'h1000 + 32'(4 * i), 1'b1, 5'((i % 31) + 1), 32'(i), i[0], 32'h800 + 32'(i), 32'(i * 3));
      cyc();
    end
    set_ev(32'h5000, 1'b0, 5'd0, '0, 1'b0, '0, '0); cyc();
    idle();
    chk("wrap_count", count, 64);
    chk("wrap_ovf", overflow, 1);
    chk("wrap_state", state, 3);
    chk("wrap_first_pc", rd_pc, 32'h1000 + 4 * 37);
    drain();
    chk("wrap_last_pc", last_pc, 32'h1000 + 4 * 100);
    chk("wrap_empty", count, 0);
    chk("wrap_stays_done", state, 3);

    // Post-trigger window of 4 captures after trigger at capture #10
    do_arm(32'h100, 4);
    for (int i = 1; i <= 16; i++) begin
      set_ev((i == 10) ? 32'h100 : 32'h2000 + 32'(4 * i), 1'b1, 5'((i % 31) + 1),
             32'hA000 + 32'(i), i[0], 32'h900 + 32'(i), 32'(i));
      cyc();
    end
    idle();
    chk("post_count", count, 14);
    chk("post_state", state, 3);
    chk("post_trig", triggered, 1);
    chk("post_ovf", overflow, 0);
    rd_ready = 1'b1;
    for (int i = 0; i < 11; i++) cyc();
    rd_ready = 1'b0;
    chk("hs_pre_count", count, 3);

    // Readout handshake table
    for (int i = 0; i < 5; i++) begin
      rd_ready = tbl[i].rdy;
      chk($sformatf("hs_valid_%0d", i), rd_valid, tbl[i].exp_v);
      cyc();
      chk($sformatf("hs_count_%0d", i), count, tbl[i].exp_cnt);
      chk($sformatf("hs_state_%0d", i), state, 3);
    end
    rd_ready = 1'b0;

    // Re-arm mid-POST; the capture in the arm cycle is dropped
    do_arm(32'h300, 20);
    for (int i = 1; i <= 7; i++) begin
      set_ev((i == 3) ? 32'h300 : 32'h3000 + 32'(4 * i), 1'b1, 5'd7, 32'(i), 1'b0, '0, '0);
      cyc();
    end
    chk("mid_count", count, 7);
    chk("mid_state", state, 2);
    arm = 1'b1; trig_pc = 32'h400; post_count = '0;
    set_ev(32'h3100, 1'b1, 5'd9, 32'hDEAD, 1'b1, 32'h44, 32'hCAFE);
    cyc();
    arm = 1'b0;
    chk("rearm_count", count, 0);
    chk("rearm_trig", triggered, 0);
    chk("rearm_ovf", overflow, 0);
    chk("rearm_state", state, 1);
    set_ev(32'h400, 1'b1, 5'd11, 32'h7777, 1'b0, '0, '0); cyc();
    idle();
    chk("rearm_done_count", count, 1);
    chk("rearm_done_state", state, 3);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
